// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD unit among NREQ val/rdy requesters.
// Define GCD_ARB_FIXED_PRIO_EN to pin priority at requester 0 (fixed priority).
module gcd_arbiter #(
  parameter int unsigned WL   = 8,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_ops_val,
  output logic [NREQ-1:0]      req_ops_rdy,
  input  logic [NREQ*WL-1:0]   req_a,
  input  logic [NREQ*WL-1:0]   req_b,
  output logic [NREQ-1:0]      req_res_val,
  input  logic [NREQ-1:0]      req_res_rdy,
  output logic [WL-1:0]        req_result,
  output logic                 gcd_ops_val,
  input  logic                 gcd_ops_rdy,
  output logic [WL-1:0]        gcd_a,
  output logic [WL-1:0]        gcd_b,
  input  logic                 gcd_res_val,
  output logic                 gcd_res_rdy,
  input  logic [WL-1:0]        gcd_result,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] prio_q, prio_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [WL-1:0]  a_q, a_d;
  logic [WL-1:0]  b_q, b_d;

  logic           found;
  logic [IDW-1:0] win;
  int unsigned    cand;

  // Rotating scan starting at prio_ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = 32'(prio_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_ops_val[cand]) begin
        found = 1'b1;
        win   = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    req_ops_rdy = '0;
    req_res_val = '0;
    req_result  = '0;
    gcd_ops_val = 1'b0;
    gcd_res_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ops_rdy = NREQ'(1) << win;
          a_d         = req_a[32'(win)*WL +: WL];
          b_d         = req_b[32'(win)*WL +: WL];
          grant_d     = win;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        gcd_ops_val = 1'b1;
        if (gcd_ops_rdy) state_d = WAIT;
      end
      WAIT: begin
        req_res_val = NREQ'(gcd_res_val) << grant_q;
        gcd_res_rdy = req_res_rdy[grant_q];
        req_result  = gcd_result;
        if (gcd_res_val && req_res_rdy[grant_q]) begin
          state_d = IDLE;
`ifdef GCD_ARB_FIXED_PRIO_EN
          prio_d  = '0;
`else
          prio_d  = (32'(grant_q) == NREQ - 1) ? '0 : IDW'(grant_q + IDW'(1));
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign gcd_a    = a_q;
  assign gcd_b    = b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter; the bench plays the GCD unit with hand-computed results.
module tb_gcd_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_ops_val, req_ops_rdy, req_res_val, req_res_rdy;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_result, gcd_a, gcd_b, gcd_result;
  logic        gcd_ops_val, gcd_ops_rdy, gcd_res_val, gcd_res_rdy, busy;
  logic [0:0]  grant_id;

  int checks = 0;
  int errors = 0;

  gcd_arbiter #(.WL(8), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_ops_val(req_ops_val), .req_ops_rdy(req_ops_rdy),
    .req_a(req_a), .req_b(req_b),
    .req_res_val(req_res_val), .req_res_rdy(req_res_rdy),
    .req_result(req_result),
    .gcd_ops_val(gcd_ops_val), .gcd_ops_rdy(gcd_ops_rdy),
    .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_res_val(gcd_res_val), .gcd_res_rdy(gcd_res_rdy),
    .gcd_result(gcd_result),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mask;
    logic [7:0] a0, b0, r0;
    logic [7:0] a1, b1, r1;
    int         g;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_ops_rdy"}, 32'(req_ops_rdy), 0);
    chk({nm, "_res_val"}, 32'(req_res_val), 0);
    chk({nm, "_result"}, 32'(req_result), 0);
    chk({nm, "_gops_val"}, 32'(gcd_ops_val), 0);
    chk({nm, "_gres_rdy"}, 32'(gcd_res_rdy), 0);
    chk({nm, "_gcd_a"}, 32'(gcd_a), 0);
    chk({nm, "_gcd_b"}, 32'(gcd_b), 0);
    chk({nm, "_grant"}, 32'(grant_id), 0);
  endtask

  // One complete transaction with no backpressure; g is the expected winner.
  task automatic run_txn(input logic [1:0] mask, input logic [7:0] a0, b0, r0,
                         input logic [7:0] a1, b1, r1, input int g);
    logic [7:0] ea, eb, er;
    ea = (g == 1) ? a1 : a0;
    eb = (g == 1) ? b1 : b0;
    er = (g == 1) ? r1 : r0;
    req_ops_val = mask;
    req_a = {a1, a0};
    req_b = {b1, b0};
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ops_rdy", 32'(req_ops_rdy), 32'(1) << g);
    tick();
    chk("iss_busy", 32'(busy), 1);
    chk("iss_grant", 32'(grant_id), 32'(g));
    chk("iss_gops_val", 32'(gcd_ops_val), 1);
    chk("iss_gcd_a", 32'(gcd_a), 32'(ea));
    chk("iss_gcd_b", 32'(gcd_b), 32'(eb));
    chk("iss_ops_rdy", 32'(req_ops_rdy), 0);
    chk("iss_res_val", 32'(req_res_val), 0);
    gcd_ops_rdy = 1'b1;
    tick();
    gcd_ops_rdy = 1'b0;
    #1;
    chk("wait_gops_val", 32'(gcd_ops_val), 0);
    gcd_res_val = 1'b1;
    gcd_result  = er;
    req_res_rdy = 2'b11;
    #1;
    chk("wait_res_val", 32'(req_res_val), 32'(1) << g);
    chk("wait_result", 32'(req_result), 32'(er));
    chk("wait_gres_rdy", 32'(gcd_res_rdy), 1);
    tick();
    gcd_res_val = 1'b0;
    req_res_rdy = 2'b00;
    req_ops_val = 2'b00;
    #1;
    chk("done_busy", 32'(busy), 0);
  endtask

  initial begin
    // Grants 1,3,5 differ between round-robin and fixed priority.
    tbl[0] = '{2'b11, 8'd48,  8'd36,  8'd12,  8'd35,  8'd14, 8'd7,  0};
    tbl[1] = '{2'b11, 8'd48,  8'd36,  8'd12,  8'd35,  8'd14, 8'd7,  1};
    tbl[2] = '{2'b11, 8'hFF,  8'hFF,  8'hFF,  8'hFE,  8'h02, 8'h02, 0};
    tbl[3] = '{2'b11, 8'hFF,  8'hFF,  8'hFF,  8'hFE,  8'h02, 8'h02, 1};
    tbl[4] = '{2'b11, 8'd100, 8'd75,  8'd25,  8'd17,  8'd5,  8'd1,  0};
    tbl[5] = '{2'b11, 8'd100, 8'd75,  8'd25,  8'd17,  8'd5,  8'd1,  1};
    tbl[6] = '{2'b10, 8'd9,   8'd6,   8'd3,   8'd81,  8'd27, 8'd27, 1};
    tbl[7] = '{2'b01, 8'd12,  8'd18,  8'd6,   8'd0,   8'd0,  8'd0,  0};
`ifdef GCD_ARB_FIXED_PRIO_EN
    tbl[1].g = 0;
    tbl[3].g = 0;
    tbl[5].g = 0;
`endif

    rst = 1'b1;
    req_ops_val = '0; req_res_rdy = '0; req_a = '0; req_b = '0;
    gcd_ops_rdy = 1'b0; gcd_res_val = 1'b0; gcd_result = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].mask, tbl[i].a0, tbl[i].b0, tbl[i].r0,
              tbl[i].a1, tbl[i].b1, tbl[i].r1, tbl[i].g);

    // Backpressure on both GCD-side handshakes for req1.
    req_ops_val = 2'b10;
    req_a = {8'd81, 8'd0};
    req_b = {8'd27, 8'd0};
    #1;
    chk("bp_ops_rdy", 32'(req_ops_rdy), 32'b10);
    tick();
    req_ops_val = 2'b11;
    req_a = {8'd1, 8'd2};
    req_b = {8'd3, 8'd4};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_iss_val", 32'(gcd_ops_val), 1);
      chk("bp_iss_a", 32'(gcd_a), 81);
      chk("bp_iss_b", 32'(gcd_b), 27);
      chk("bp_iss_ops_rdy", 32'(req_ops_rdy), 0);
      tick();
    end
    gcd_ops_rdy = 1'b1;
    tick();
    gcd_ops_rdy = 1'b0;
    gcd_res_val = 1'b1;
    gcd_result  = 8'd27;
    req_res_rdy = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_wait_gres_rdy", 32'(gcd_res_rdy), 0);
      chk("bp_wait_res_val", 32'(req_res_val), 32'b10);
      chk("bp_wait_busy", 32'(busy), 1);
      chk("bp_wait_ops_rdy", 32'(req_ops_rdy), 0);
      tick();
    end
    req_res_rdy = 2'b10;
    #1;
    chk("bp_gres_rdy", 32'(gcd_res_rdy), 1);
    chk("bp_result", 32'(req_result), 27);
    tick();
    gcd_res_val = 1'b0;
    req_res_rdy = 2'b00;
    #1;
    chk("bp_done_busy", 32'(busy), 0);
    chk("bp_next_rdy", 32'(req_ops_rdy), 32'b01);
    req_ops_val = 2'b00;

    // Reset while req1 waits, with prio_ptr moved to 1 beforehand (round-robin).
    run_txn(2'b01, 8'd12, 8'd18, 8'd6, 8'd0, 8'd0, 8'd0, 0);
    req_ops_val = 2'b10;
    req_a = {8'd35, 8'd0};
    req_b = {8'd14, 8'd0};
    tick();
    gcd_ops_rdy = 1'b1;
    tick();
    gcd_ops_rdy = 1'b0;
    req_ops_val = 2'b11;
    #1;
    chk("rstw_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_ops_val = 2'b00;
    req_a = '0;
    req_b = '0;
    #1;
    chk_all_zero("rstw");
    req_ops_val = 2'b11;
    #1;
    chk("rstw_prio", 32'(req_ops_rdy), 32'b01);
    req_ops_val = 2'b00;
    run_txn(2'b01, 8'd12, 8'd18, 8'd6, 8'd0, 8'd0, 8'd0, 0);

    // Stray result pulse in IDLE.
    gcd_res_val = 1'b1;
    gcd_result  = 8'h55;
    req_res_rdy = 2'b11;
    #1;
    chk("stray_gres_rdy", 32'(gcd_res_rdy), 0);
    chk("stray_res_val", 32'(req_res_val), 0);
    chk("stray_result", 32'(req_result), 0);
    tick();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_res_val2", 32'(req_res_val), 0);
    gcd_res_val = 1'b0;
    req_res_rdy = 2'b00;
    run_txn(2'b10, 8'd0, 8'd0, 8'd0, 8'd81, 8'd27, 8'd27, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
